// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the NPC core sequencer: state encodings, counter
// defaults and instruction-class flag bit positions used by the decode stage.
package core_seq_ctrl_pkg;

    localparam int unsigned STATE_W         = 4;
    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;
    localparam int unsigned INSTRET_W_DEF   = 32;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE       = 4'd0,
        S_FETCH_REQ  = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC       = 4'd4,
        S_MEM_REQ    = 4'd5,
        S_MEM_WAIT   = 4'd6,
        S_WB         = 4'd7,
        S_HALT       = 4'd8,
        S_TRAP       = 4'd9
    } state_e;

    // Instruction-class flag vector layout, as produced by the decode stage
    localparam int unsigned CLS_INV    = 0;
    localparam int unsigned CLS_EBREAK = 1;
    localparam int unsigned CLS_LOAD   = 2;
    localparam int unsigned CLS_STORE  = 3;
    localparam int unsigned CLS_RD_WEN = 4;
    localparam int unsigned CLS_W      = 5;

    // Class information carried from DECODE into EXEC/WB
    typedef struct packed {
        logic mem;
        logic store;
        logic rd_wen;
    } seq_cls_t;

endpackage

// File: rtl/core_seq_ctrl_wait_timer.sv
// Clearable saturating wait counter with a limit compare, used to bound the
// request+wait phases of fetch and data-memory accesses.
module seq_wait_timer #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_c = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle control FSM for the NPC core: sequences fetch, decode, execute,
// memory and writeback, and stops on ebreak, invalid instruction or timeout.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned INSTRET_W   = INSTRET_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ifu_req_valid,
    input  logic                 ifu_req_ready,
    input  logic                 ifu_rsp_valid,
    input  logic                 dec_inv,
    input  logic                 dec_ebreak,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic                 dec_rd_wen,
    output logic                 lsu_req_valid,
    input  logic                 lsu_req_ready,
    input  logic                 lsu_rsp_valid,
    output logic                 ir_we,
    output logic                 rf_we,
    output logic                 pc_we,
    output logic                 halt,
    output logic                 trap,
    output logic                 trap_timeout,
    output logic [INSTRET_W-1:0] instret,
    output logic [STATE_W-1:0]   state
);

    state_e                 state_q, state_d;
    seq_cls_t               cls_q, cls_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   trap_to_q, trap_to_d;
    logic [CLS_W-1:0]       dec_cls_c;
    logic                   timer_clr_c;
    logic                   timer_inc_c;
    logic                   at_limit_c;

    assign dec_cls_c[CLS_INV]    = dec_inv;
    assign dec_cls_c[CLS_EBREAK] = dec_ebreak;
    assign dec_cls_c[CLS_LOAD]   = dec_load;
    assign dec_cls_c[CLS_STORE]  = dec_store;
    assign dec_cls_c[CLS_RD_WEN] = dec_rd_wen;

    assign timer_inc_c = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) ||
                         (state_q == S_MEM_REQ)   || (state_q == S_MEM_WAIT);

    seq_wait_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (timer_clr_c),
        .inc        (timer_inc_c),
        .at_limit_c (at_limit_c)
    );

    // Next-state, counters and state-decoded strobes
    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        instret_d     = instret_q;
        trap_to_d     = trap_to_q;
        timer_clr_c   = 1'b0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        ir_we         = 1'b0;
        rf_we         = 1'b0;
        pc_we         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d     = S_FETCH_REQ;
                timer_clr_c = 1'b1;
            end
            S_FETCH_REQ: begin
                ifu_req_valid = 1'b1;
                if (at_limit_c) begin
                    state_d   = S_TRAP;
                    trap_to_d = 1'b1;
                end else if (ifu_req_ready) begin
                    state_d = S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: begin
                ir_we = ifu_rsp_valid;
                // A response on the limit cycle still completes the phase
                if (ifu_rsp_valid) begin
                    state_d = S_DECODE;
                end else if (at_limit_c) begin
                    state_d   = S_TRAP;
                    trap_to_d = 1'b1;
                end
            end
            S_DECODE: begin
                cls_d.mem    = dec_cls_c[CLS_LOAD] | dec_cls_c[CLS_STORE];
                cls_d.store  = dec_cls_c[CLS_STORE];
                cls_d.rd_wen = dec_cls_c[CLS_RD_WEN];
                if (dec_cls_c[CLS_INV]) begin
                    state_d = S_TRAP;
                end else if (dec_cls_c[CLS_EBREAK]) begin
                    state_d   = S_HALT;
                    instret_d = instret_q + INSTRET_W'(1);
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_q.mem) begin
                    state_d     = S_MEM_REQ;
                    timer_clr_c = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM_REQ: begin
                lsu_req_valid = 1'b1;
                if (at_limit_c) begin
                    state_d   = S_TRAP;
                    trap_to_d = 1'b1;
                end else if (lsu_req_ready) begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    state_d = S_WB;
                end else if (at_limit_c) begin
                    state_d   = S_TRAP;
                    trap_to_d = 1'b1;
                end
            end
            S_WB: begin
                pc_we       = 1'b1;
                rf_we       = cls_q.rd_wen & ~cls_q.store;
                instret_d   = instret_q + INSTRET_W'(1);
                state_d     = S_FETCH_REQ;
                timer_clr_c = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cls_q     <= '0;
            instret_q <= '0;
            trap_to_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            instret_q <= instret_d;
            trap_to_q <= trap_to_d;
        end
    end

    assign halt         = (state_q == S_HALT);
    assign trap         = (state_q == S_TRAP);
    assign trap_timeout = trap_to_q;
    assign instret      = instret_q;
    assign state        = state_q;

endmodule
